// File: rtl/stream_reduce_accumulator_pkg.sv
// Purpose: shared FSM encoding, mode constants and helpers for the stream reduce accumulator.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
package stream_reduce_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  localparam int ADD_INT   = 0;
  localparam int ADD_FLOAT = 1;

  // Smallest r with 2^r >= n; n=1 yields 0 (no tree layers).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // IEEE-754 single add, round-to-nearest-even, gradual underflow.
  // Operands are ordered by magnitude so the result sign is always the larger one's.
  function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] rm;
    logic        sticky, rnd;
    logic        x_nan, y_nan, x_inf, y_inf;

    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    x_nan = (&x[30:23]) & (|x[22:0]);
    y_nan = (&y[30:23]) & (|y[22:0]);
    x_inf = (&x[30:23]) & ~(|x[22:0]);
    y_inf = (&y[30:23]) & ~(|y[22:0]);

    // Denormals use exponent 1 with no hidden bit.
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};

    // Align the smaller operand; every bit shifted out folds into sticky.
    d = ex - ey;
    sticky = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (8'(i) < d) sticky = sticky | my[i];
    end
    my    = (d >= 8'd27) ? 27'd0 : (my >> d);
    my[0] = my[0] | sticky;

    s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    e = {2'b00, ex};

    // Carry out: shift right once, keep sticky.
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    // Cancellation: shift left until normalised or the denormal floor is hit.
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && (e > 10'd1)) begin
        s = s << 1;
        e = e - 10'd1;
      end
    end

    rnd = s[2] & (s[1] | s[0] | s[3]);
    rm  = {1'b0, s[26:3]} + {24'd0, rnd};
    if (rm[24]) begin
      rm = rm >> 1;
      e  = e + 10'd1;
    end

    if (x_nan || y_nan) begin
      res = 32'h7FC0_0000;
    end else if (x_inf) begin
      res = (y_inf && (x[31] != y[31])) ? 32'h7FC0_0000 : x;
    end else if (s == 28'd0) begin
      res = {x[31] & y[31], 31'd0};
    end else if (e >= 10'd255) begin
      res = {x[31], 8'hFF, 23'd0};
    end else begin
      res = {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_reduce_accumulator_add_lane.sv
// Purpose: one DATA_W two-input adder, integer or IEEE-754 single by FLOAT.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module stream_reduce_accumulator_add_lane
  import stream_reduce_accumulator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FLOAT  = ADD_INT
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  if (FLOAT == ADD_FLOAT) begin : g_f32
    // Float mode is only meaningful with DATA_W = 32.
    assign sum_o = f32_add(a_i, b_i);
  end else begin : g_int
    // Carry-in tied low; wraps modulo 2^DATA_W with no overflow flag.
    assign sum_o = a_i + b_i;
  end

endmodule

// File: rtl/stream_reduce_accumulator.sv
// Purpose: reduces each N_IN-lane beat through a shared adder tree and accumulates beats until in_last.
// Latency: LAYERS+1 cycles accept-to-out_valid for a one-beat sum; one beat every LAYERS+2 cycles.
// Backpressure: in_ready only in IDLE (no input buffer); result held in OUT until out_ready; en=0 freezes all.
module stream_reduce_accumulator
  import stream_reduce_accumulator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 16,
  parameter int FLOAT  = ADD_INT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [DATA_W*N_IN-1:0] in_vals,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int LAYERS = clog2(N_IN);
  localparam int P      = 1 << LAYERS;
  localparam int HALF   = P / 2;
  localparam logic [7:0] LAST_LAYER = 8'((LAYERS > 0) ? (LAYERS - 1) : 0);

  state_t            state_q, state_d;
  logic [7:0]        layer_q;
  logic              last_q;
  logic              rst_done_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] out_sum_q;
  logic [DATA_W-1:0] acc_sum;
  logic [DATA_W-1:0] tree_q  [P];
  logic [DATA_W-1:0] lane_in [P];
  logic [DATA_W-1:0] lvl_sum [(HALF > 0) ? HALF : 1];
  logic              accept;

  // Pad the beat out to a power-of-two tree; missing lanes contribute zero.
  for (genvar g = 0; g < P; g++) begin : g_pad
    if (g < N_IN) begin : g_live
      assign lane_in[g] = in_vals[g*DATA_W +: DATA_W];
    end else begin : g_zero
      assign lane_in[g] = '0;
    end
  end

  // One shared layer of adders, reused every REDUCE cycle.
  for (genvar g = 0; g < HALF; g++) begin : g_tree
    stream_reduce_accumulator_add_lane #(
      .DATA_W (DATA_W),
      .FLOAT  (FLOAT)
    ) u_add (
      .a_i   (tree_q[2*g]),
      .b_i   (tree_q[2*g+1]),
      .sum_o (lvl_sum[g])
    );
  end

  if (HALF == 0) begin : g_no_tree
    assign lvl_sum[0] = '0;
  end

  stream_reduce_accumulator_add_lane #(
    .DATA_W (DATA_W),
    .FLOAT  (FLOAT)
  ) u_acc_add (
    .a_i   (acc_q),
    .b_i   (tree_q[0]),
    .sum_o (acc_sum)
  );

  // Handshake decode; rst_done_q keeps in_ready low while reset is asserted.
  always_comb begin
    in_ready = rst_done_q && (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  assign accept    = en && !clr && in_valid && in_ready;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;

  // Next-state logic: nothing moves while en=0; clr wins over every transition.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (clr) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:   if (accept) state_d = (LAYERS == 0) ? ST_ACCUM : ST_REDUCE;
          ST_REDUCE: if (layer_q == LAST_LAYER) state_d = ST_ACCUM;
          ST_ACCUM:  state_d = last_q ? ST_OUT : ST_IDLE;
          ST_OUT:    if (out_ready) state_d = ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: tree load/reduce, accumulate, result hand-off; frozen while en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P; i++) tree_q[i] <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      layer_q     <= 8'd0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (en) begin
        if (clr) begin
          acc_q       <= '0;
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          layer_q     <= 8'd0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (accept) begin
                for (int i = 0; i < P; i++) tree_q[i] <= lane_in[i];
                last_q  <= in_last;
                layer_q <= 8'd0;
              end
            end
            ST_REDUCE: begin
              for (int i = 0; i < HALF; i++) tree_q[i] <= lvl_sum[i];
              for (int i = HALF; i < P; i++) tree_q[i] <= '0;
              layer_q <= layer_q + 8'd1;
            end
            ST_ACCUM: begin
              acc_q   <= acc_sum;
              layer_q <= 8'd0;
              if (last_q) begin
                out_sum_q   <= acc_sum;
                out_valid_q <= 1'b1;
              end
            end
            ST_OUT: begin
              if (out_ready) begin
                out_valid_q <= 1'b0;
                acc_q       <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_reduce_accumulator.sv
// Purpose: directed checks of the stream reduce accumulator (16-lane int, 5-lane int, 16-lane float).
// Latency: checks accept-to-result latency, beat spacing, en stalls, clr and rst aborts.
// Backpressure: exercises out_ready hold-off and in_ready gating between beats.
module tb_stream_reduce_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  logic [511:0] vals16 = '0;
  logic         vld16 = 1'b0, last16 = 1'b0, ordy16 = 1'b0;
  logic         rdy16, ovld16, busy16;
  logic [31:0]  sum16;

  logic [159:0] vals5 = '0;
  logic         vld5 = 1'b0, last5 = 1'b0, ordy5 = 1'b0;
  logic         rdy5, ovld5, busy5;
  logic [31:0]  sum5;

  logic [511:0] valsf = '0;
  logic         vldf = 1'b0, lastf = 1'b0, ordyf = 1'b0;
  logic         rdyf, ovldf, busyf;
  logic [31:0]  sumf;

  int n_cmp = 0;
  int n_err = 0;

  stream_reduce_accumulator #(.DATA_W(32), .N_IN(16), .FLOAT(0)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_vals(vals16), .in_valid(vld16), .in_last(last16), .in_ready(rdy16),
    .out_sum(sum16), .out_valid(ovld16), .out_ready(ordy16), .busy(busy16)
  );

  stream_reduce_accumulator #(.DATA_W(32), .N_IN(5), .FLOAT(0)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_vals(vals5), .in_valid(vld5), .in_last(last5), .in_ready(rdy5),
    .out_sum(sum5), .out_valid(ovld5), .out_ready(ordy5), .busy(busy5)
  );

  stream_reduce_accumulator #(.DATA_W(32), .N_IN(16), .FLOAT(1)) u_dutf (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_vals(valsf), .in_valid(vldf), .in_last(lastf), .in_ready(rdyf),
    .out_sum(sumf), .out_valid(ovldf), .out_ready(ordyf), .busy(busyf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] fill16(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] ramp16();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(i + 1);
    return r;
  endfunction

  task automatic beat16(input logic [511:0] v, input logic l);
    int k;
    k = 0;
    while (!rdy16 && k < 50) begin
      tick();
      k++;
    end
    chk("in_ready_wait", {31'd0, rdy16}, 32'd1);
    vals16 = v;
    last16 = l;
    vld16  = 1'b1;
    tick();
    vld16  = 1'b0;
    last16 = 1'b0;
  endtask

  task automatic wait_out16(output int n);
    n = 0;
    while (!ovld16 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic take16();
    ordy16 = 1'b1;
    tick();
    ordy16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, rdy16}, 32'd0);
    chk("rst_out_valid", {31'd0, ovld16}, 32'd0);
    chk("rst_out_sum", sum16, 32'd0);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_busy5", {31'd0, busy5}, 32'd0);
    chk("rst_busyf", {31'd0, busyf}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", {31'd0, rdy16}, 32'd1);

    // Single beat 1..16: 136 after 5 cycles.
    beat16(ramp16(), 1'b1);
    chk("busy_reduce", {31'd0, busy16}, 32'd1);
    wait_out16(n);
    chk("lat_single", n, 32'd5);
    chk("sum_ramp", sum16, 32'd136);
    chk("rdy_in_out", {31'd0, rdy16}, 32'd0);
    take16();
    chk("ovld_taken", {31'd0, ovld16}, 32'd0);
    chk("rdy_after_take", {31'd0, rdy16}, 32'd1);

    // Three beats of all-2: 96; in_ready low between beats, spacing 6 cycles.
    beat16(fill16(32'd2), 1'b0);
    chk("rdy_between", {31'd0, rdy16}, 32'd0);
    n = 0;
    while (!rdy16 && n < 50) begin
      tick();
      n++;
    end
    chk("beat_gap", n, 32'd5);
    chk("no_out_mid_sum", {31'd0, ovld16}, 32'd0);
    beat16(fill16(32'd2), 1'b0);
    beat16(fill16(32'd2), 1'b1);
    wait_out16(n);
    chk("sum_three_beats", sum16, 32'd96);
    take16();

    // Wrap: 16 x 0xFFFFFFFF; then hold out_ready low 10 cycles.
    beat16(fill16(32'hFFFF_FFFF), 1'b1);
    wait_out16(n);
    chk("sum_wrap", sum16, 32'hFFFF_FFF0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_sum", sum16, 32'hFFFF_FFF0);
      chk("hold_rdy", {31'd0, rdy16}, 32'd0);
    end
    chk("hold_valid", {31'd0, ovld16}, 32'd1);
    take16();
    chk("idle_after_take", {31'd0, busy16}, 32'd0);
    chk("rdy_after_hold", {31'd0, rdy16}, 32'd1);
    beat16(fill16(32'd1), 1'b1);
    wait_out16(n);
    chk("acc_cleared", sum16, 32'd16);
    take16();

    // en=0 in IDLE: beat offered but not accepted.
    en = 1'b0;
    vals16 = ramp16();
    last16 = 1'b1;
    vld16 = 1'b1;
    tick();
    tick();
    chk("en0_no_accept", {31'd0, busy16}, 32'd0);
    chk("en0_rdy_held", {31'd0, rdy16}, 32'd1);
    vld16 = 1'b0;
    last16 = 1'b0;
    en = 1'b1;

    // en=0 for 3 cycles mid-REDUCE: result delayed exactly 3 cycles.
    beat16(ramp16(), 1'b1);
    tick();
    en = 1'b0;
    repeat (3) tick();
    chk("en0_busy", {31'd0, busy16}, 32'd1);
    chk("en0_ovld", {31'd0, ovld16}, 32'd0);
    en = 1'b1;
    wait_out16(n);
    t = 4 + n;
    chk("lat_en_stall", t, 32'd8);
    chk("sum_en_stall", sum16, 32'd136);
    // Consumer ready while en=0: no transfer.
    en = 1'b0;
    ordy16 = 1'b1;
    tick();
    chk("en0_no_transfer", {31'd0, ovld16}, 32'd1);
    en = 1'b1;
    tick();
    ordy16 = 1'b0;
    chk("transfer_en1", {31'd0, ovld16}, 32'd0);

    // rst during REDUCE.
    beat16(fill16(32'd3), 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy16}, 32'd0);
    chk("rst_mid_rdy", {31'd0, rdy16}, 32'd0);
    chk("rst_mid_ovld", {31'd0, ovld16}, 32'd0);
    chk("rst_mid_sum", sum16, 32'd0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst2", {31'd0, rdy16}, 32'd1);

    // clr in OUT drops the result and the accumulator.
    beat16(ramp16(), 1'b1);
    wait_out16(n);
    chk("ovld_before_clr", {31'd0, ovld16}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovld", {31'd0, ovld16}, 32'd0);
    chk("clr_busy", {31'd0, busy16}, 32'd0);
    chk("clr_rdy", {31'd0, rdy16}, 32'd1);
    beat16(fill16(32'd2), 1'b1);
    wait_out16(n);
    chk("sum_after_clr", sum16, 32'd32);
    take16();

    // N_IN=5 (P=8): 10+20+30+40+50 after 4 cycles.
    chk("rdy5", {31'd0, rdy5}, 32'd1);
    for (int i = 0; i < 5; i++) vals5[i*32 +: 32] = 32'(10 * (i + 1));
    vld5 = 1'b1;
    last5 = 1'b1;
    tick();
    vld5 = 1'b0;
    last5 = 1'b0;
    n = 0;
    while (!ovld5 && n < 50) begin
      tick();
      n++;
    end
    chk("lat_n5", n, 32'd4);
    chk("sum_n5", sum5, 32'd150);
    ordy5 = 1'b1;
    tick();
    ordy5 = 1'b0;

    // Float: 16 x 1.5 = 24.0, then alternating +1.0/-1.0 = +0.0.
    chk("rdyf", {31'd0, rdyf}, 32'd1);
    valsf = fill16(32'h3FC0_0000);
    vldf = 1'b1;
    lastf = 1'b1;
    tick();
    vldf = 1'b0;
    lastf = 1'b0;
    n = 0;
    while (!ovldf && n < 50) begin
      tick();
      n++;
    end
    chk("lat_f32", n, 32'd5);
    chk("sum_f32", sumf, 32'h41C0_0000);
    ordyf = 1'b1;
    tick();
    ordyf = 1'b0;
    for (int i = 0; i < 16; i++) valsf[i*32 +: 32] = (i % 2 == 0) ? 32'h3F80_0000 : 32'hBF80_0000;
    vldf = 1'b1;
    lastf = 1'b1;
    tick();
    vldf = 1'b0;
    lastf = 1'b0;
    n = 0;
    while (!ovldf && n < 50) begin
      tick();
      n++;
    end
    chk("sum_f32_cancel", sumf, 32'h0000_0000);
    ordyf = 1'b1;
    tick();
    ordyf = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
